// File: rtl/inst_package.sv
// Shared instruction-set constants and the fetch-stage state encoding.
package inst_package;

  localparam logic [5:0]  Nop        = 6'h3f;
  localparam logic [63:0] NOP_BUNDLE = {Nop, 26'b0, Nop, 26'b0};

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    STALL,
    REDIRECT
  } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch: drives a 1-cycle-latency bundle BRAM and presents pc/inst to decode.
// Optional FETCH_STAT_EN adds saturating bundle/stall/flush counters.
module fetch
  import inst_package::*;
#(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              interlock,
  input  logic              branch_flag,
  input  logic [31:0]       branch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [63:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [63:0]       inst,
  output logic              running
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]       stat_bundles,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_flush
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  req_pc, req_pc_nxt, req_pc_inc;
  logic [63:0]  hold_inst;
  logic         capture;

  assign req_pc_inc = req_pc + 32'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      req_pc    <= 32'd0;
      hold_inst <= NOP_BUNDLE;
    end else begin
      state  <= state_nxt;
      req_pc <= req_pc_nxt;
      if (capture) hold_inst <= imem_rdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_pc_nxt = req_pc;
    imem_addr  = req_pc[ADDR_W-1:0];
    imem_en    = 1'b0;
    pc         = req_pc;
    inst       = NOP_BUNDLE;
    running    = 1'b1;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        pc      = 32'd0;
        running = 1'b0;
        if (start) begin
          req_pc_nxt = RESET_PC;
          state_nxt  = PRIME;
        end
      end
      PRIME: begin
        imem_en   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        inst = imem_rdata;
        if (interlock) begin
          capture   = 1'b1;
          state_nxt = STALL;
        end else begin
          imem_en    = 1'b1;
          imem_addr  = req_pc_inc[ADDR_W-1:0];
          req_pc_nxt = req_pc_inc;
        end
      end
      STALL: begin
        inst = hold_inst;
        // Leaving the stall: the held bundle is consumed this cycle, so fetch the next one.
        if (!interlock) begin
          imem_en    = 1'b1;
          imem_addr  = req_pc_inc[ADDR_W-1:0];
          req_pc_nxt = req_pc_inc;
          state_nxt  = RUN;
        end
      end
      REDIRECT: begin
        pc        = 32'd0;
        imem_en   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && branch_flag) begin
      capture    = 1'b0;
      imem_en    = 1'b1;
      imem_addr  = branch_pc[ADDR_W-1:0];
      req_pc_nxt = branch_pc;
      state_nxt  = REDIRECT;
    end
  end

`ifdef FETCH_STAT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_bundles <= 32'd0;
      stat_stall   <= 32'd0;
      stat_flush   <= 32'd0;
    end else begin
      if (state == RUN && !interlock && !branch_flag && stat_bundles != '1)
        stat_bundles <= stat_bundles + 32'd1;
      if (state == STALL && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
      if (state != IDLE && branch_flag && stat_flush != '1)
        stat_flush <= stat_flush + 32'd1;
    end
  end
`endif

endmodule
